usb_tx_line_encoder: RTL and testbench

//  Final stage of the USB transmit path, directly downstream of the stuff-bit detector.

---
 rtl/usb_tx_line_encoder.sv | 122 ++++++++++++
 tb/tb_usb_tx_line_encoder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/usb_tx_line_encoder.sv
// usb_tx_line_encoder: NRZI line encoder with bit-stuff insertion and EOP generation
module usb_tx_line_encoder #(
  parameter int EOP_SE0_BITS = 2,
  parameter int EOP_J_BITS   = 1
) (
  input  logic clk,
  input  logic n_rst,
  input  logic shift_enable,
  input  logic d_orig,
  input  logic bit_stuff,
  input  logic tx_active,
  input  logic send_eop,
  output logic dplus_out,
  output logic dminus_out,
  output logic busy,
  output logic eop_done
);
  typedef enum logic [1:0] {IDLE, DATA, EOP_SE0, EOP_J} state_t;
  localparam logic [2:0] SE0_N = 3'(EOP_SE0_BITS);
  localparam logic [2:0] J_N   = 3'(EOP_J_BITS);
  state_t r_state, w_state_nx;
  logic r_nrzi, w_nrzi_nx;
  logic r_dp, w_dp_nx;
  logic r_dm, w_dm_nx;
  logic r_eop_done, w_eop_done_nx;
  logic r_pend, w_pend_nx;
  logic [2:0] r_cnt, w_cnt_nx;
  logic w_lvl;
  assign w_lvl      = (bit_stuff | ~d_orig) ? ~r_nrzi : r_nrzi;
  assign dplus_out  = r_dp;
  assign dminus_out = r_dm;
  assign busy       = r_state != IDLE;
  assign eop_done   = r_eop_done;
  // State and registered line outputs; reset forces idle J immediately
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= IDLE;
      r_nrzi     <= 1'b1;
      r_dp       <= 1'b1;
      r_dm       <= 1'b0;
      r_eop_done <= 1'b0;
      r_pend     <= 1'b0;
      r_cnt      <= 3'd0;
    end else begin
      r_state    <= w_state_nx;
      r_nrzi     <= w_nrzi_nx;
      r_dp       <= w_dp_nx;
      r_dm       <= w_dm_nx;
      r_eop_done <= w_eop_done_nx;
      r_pend     <= w_pend_nx;
      r_cnt      <= w_cnt_nx;
    end
  end
  // Next state: encode data per strobe, defer EOP past any stuffed bit, count EOP bit-times
  always_comb begin
    w_state_nx    = r_state;
    w_nrzi_nx     = r_nrzi;
    w_dp_nx       = r_dp;
    w_dm_nx       = r_dm;
    w_eop_done_nx = 1'b0;
    w_pend_nx     = r_pend;
    w_cnt_nx      = r_cnt;
    case (r_state)
      IDLE: begin
        w_nrzi_nx = 1'b1;
        w_dp_nx   = 1'b1;
        w_dm_nx   = 1'b0;
        w_pend_nx = 1'b0;
        w_cnt_nx  = 3'd0;
        if (tx_active) w_state_nx = DATA;
      end
      DATA: begin
        if (!tx_active) begin
          w_state_nx = IDLE;
          w_nrzi_nx  = 1'b1;
          w_dp_nx    = 1'b1;
          w_dm_nx    = 1'b0;
          w_pend_nx  = 1'b0;
        end else begin
          w_pend_nx = r_pend | send_eop;
          if (shift_enable) begin
            if (r_pend && !bit_stuff) begin
              w_state_nx = EOP_SE0;
              w_dp_nx    = 1'b0;
              w_dm_nx    = 1'b0;
              w_cnt_nx   = 3'd1;
              w_pend_nx  = 1'b0;
            end else begin
              w_nrzi_nx = w_lvl;
              w_dp_nx   = w_lvl;
              w_dm_nx   = ~w_lvl;
            end
          end
        end
      end
      EOP_SE0: begin
        if (shift_enable) begin
          if (r_cnt < SE0_N) begin
            w_cnt_nx = r_cnt + 3'd1;
          end else begin
            w_state_nx = EOP_J;
            w_dp_nx    = 1'b1;
            w_dm_nx    = 1'b0;
            w_cnt_nx   = 3'd1;
          end
        end
      end
      EOP_J: begin
        if (shift_enable) begin
          if (r_cnt < J_N) begin
            w_cnt_nx = r_cnt + 3'd1;
          end else begin
            w_state_nx    = IDLE;
            w_nrzi_nx     = 1'b1;
            w_eop_done_nx = 1'b1;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// tb_usb_tx_line_encoder: directed and randomized checks against a bit-time level NRZI model
module tb_usb_tx_line_encoder;
  logic clk = 1'b0, n_rst = 1'b0;
  logic shift_enable = 1'b0, d_orig = 1'b0, bit_stuff = 1'b0, tx_active = 1'b0, send_eop = 1'b0;
  logic dplus_out, dminus_out, busy, eop_done;
  int n_tests = 0, n_fail = 0;
  logic m_lvl = 1'b1;
  logic [3:0] last = 4'b1000;
  always #5 clk = ~clk;
  usb_tx_line_encoder dut (
    .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .d_orig(d_orig),
    .bit_stuff(bit_stuff), .tx_active(tx_active), .send_eop(send_eop),
    .dplus_out(dplus_out), .dminus_out(dminus_out), .busy(busy), .eop_done(eop_done)
  );
  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {dplus_out, dminus_out, busy, eop_done};
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: {dp,dm,busy,done} got %b expected %b", tag, obs, exp);
    end
    last = exp;
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic gap(input int n);
    repeat (n) begin
      cyc();
      chk("hold", {last[3:1], 1'b0});
    end
  endtask
  task automatic strobe(input logic bs, input logic d, input logic eop, input logic [3:0] exp, input string tag);
    shift_enable = 1'b1;
    bit_stuff = bs;
    d_orig = d;
    send_eop = eop;
    cyc();
    shift_enable = 1'b0;
    bit_stuff = 1'b0;
    d_orig = 1'b0;
    send_eop = 1'b0;
    chk(tag, exp);
  endtask
  task automatic data(input logic bs, input logic d, input logic eop);
    logic bit_v;
    bit_v = bs ? 1'b0 : d;
    if (bit_v == 1'b0) m_lvl = ~m_lvl;
    strobe(bs, d, eop, {m_lvl, ~m_lvl, 2'b10}, "data");
  endtask
  task automatic start();
    tx_active = 1'b1;
    m_lvl = 1'b1;
    cyc();
    chk("start", 4'b1010);
    gap($urandom_range(0, 2));
  endtask
  task automatic request_eop();
    send_eop = 1'b1;
    cyc();
    send_eop = 1'b0;
    chk("eop_req", {last[3:1], 1'b0});
  endtask
  task automatic tail();
    strobe(1'b0, 1'($urandom), 1'b0, 4'b0010, "se0_1");
    tx_active = 1'($urandom);
    gap($urandom_range(0, 2));
    strobe(1'($urandom), 1'($urandom), 1'b0, 4'b0010, "se0_2");
    gap($urandom_range(0, 2));
    strobe(1'($urandom), 1'($urandom), 1'b0, 4'b1010, "eop_j");
    tx_active = 1'b0;
    gap($urandom_range(0, 2));
    strobe(1'($urandom), 1'($urandom), 1'b0, 4'b1001, "eop_done");
    m_lvl = 1'b1;
    cyc();
    chk("idle_after", 4'b1000);
  endtask
  task automatic packet(input int nbits, input bit same_cycle_eop, input bit stuff_first);
    start();
    for (int i = 0; i < nbits; i++) begin
      data(($urandom_range(0, 5) == 0), 1'($urandom), same_cycle_eop && (i == nbits - 1));
      gap($urandom_range(0, 2));
    end
    if (!same_cycle_eop) request_eop();
    if (stuff_first) begin
      data(1'b1, 1'($urandom), 1'b0);
      gap($urandom_range(0, 1));
    end
    tail();
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 4'b1000);
    n_rst = 1'b1;
    cyc();
    chk("idle", 4'b1000);
    // bits 0,0,1,1 give D+ 0,1,1,1
    start();
    data(1'b0, 1'b0, 1'b0);
    chk("t1_b0", 4'b0110);
    data(1'b0, 1'b0, 1'b0);
    data(1'b0, 1'b1, 1'b0);
    data(1'b0, 1'b1, 1'b0);
    chk("t1_b3", 4'b1010);
    // six ones then a stuffed zero
    for (int i = 0; i < 6; i++) data(1'b0, 1'b1, 1'b0);
    data(1'b1, 1'b1, 1'b1);
    chk("t2_stuff", 4'b0110);
    tail();
    // EOP requested, next strobe carries a stuffed bit first
    start();
    data(1'b0, 1'b1, 1'b0);
    request_eop();
    data(1'b1, 1'b1, 1'b0);
    chk("t4_stuff_first", 4'b0110);
    tail();
    // abort mid-DATA
    start();
    data(1'b0, 1'b0, 1'b0);
    data(1'b0, 1'b1, 1'b1);
    tx_active = 1'b0;
    cyc();
    chk("abort", 4'b1000);
    gap(3);
    // abort clears a pending EOP: next packet encodes data on its first strobe
    start();
    data(1'b0, 1'b0, 1'b0);
    chk("after_abort", 4'b0110);
    tx_active = 1'b0;
    cyc();
    chk("abort2", 4'b1000);
    // async reset during SE0
    start();
    data(1'b0, 1'b0, 1'b1);
    strobe(1'b0, 1'b0, 1'b0, 4'b0010, "rst_se0");
    #2 n_rst = 1'b0;
    tx_active = 1'b0;
    #1 chk("async_rst", 4'b1000);
    cyc();
    n_rst = 1'b1;
    cyc();
    chk("post_rst", 4'b1000);
    start();
    data(1'b0, 1'b0, 1'b0);
    chk("post_rst_first", 4'b0110);
    tx_active = 1'b0;
    cyc();
    chk("post_rst_abort", 4'b1000);
    // randomized packets
    for (int p = 0; p < 25; p++)
      packet($urandom_range(1, 12), 1'($urandom), 1'($urandom));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
